riscv_seq_ctrl: RTL and testbench

Multi-cycle control unit for the reduced RISC-V datapath (register file, operand mux, ALU).
- Fetches instructions over a valid-handshake instruction-memory port.
- Decodes and drives the datapath control inputs: rs1, rs2, rd, en, ALUSrc, ImmOp, ALU_ctrl.
- Resolves bne from the ALU eq flag and owns the PC.
- Supports addi, add and bne; any other encoding halts the core.

---
 rtl/riscv_ctrl_pkg.sv | 43 ++++
 rtl/riscv_seq_ctrl_imm_gen.sv | 25 ++
 rtl/riscv_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_riscv_seq_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared constants, state and instruction-class types for the reduced RISC-V control unit.
// The decoder only recognises addi, add and bne; anything else classifies as illegal.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [6:0] F7_ADD = 7'b0000000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    ERROR  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_ADDI    = 2'd0,
    CLS_ADD     = 2'd1,
    CLS_BNE     = 2'd2,
    CLS_ILLEGAL = 2'd3
  } instr_cls_t;

  function automatic instr_cls_t classify(input logic [31:0] instr);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    opcode = instr[6:0];
    funct3 = instr[14:12];
    funct7 = instr[31:25];
    if (opcode == OP_IMM && funct3 == F3_ADD) return CLS_ADDI;
    if (opcode == OP_REG && funct3 == F3_ADD && funct7 == F7_ADD) return CLS_ADD;
    if (opcode == OP_BRANCH && funct3 == F3_BNE) return CLS_BNE;
    return CLS_ILLEGAL;
  endfunction

endpackage

// File: rtl/riscv_seq_ctrl_imm_gen.sv
// Immediate extraction for the control unit: I-type for addi, B-type for bne,
// both sign-extended to the datapath width.
module riscv_seq_ctrl_imm_gen #(
  parameter int W = 32
) (
  input  logic [31:0]  instr,
  input  logic         is_branch,
  output logic [W-1:0] imm
);

  logic [11:0] imm_i;
  logic [12:0] imm_b;
  logic        unused_bits;

  assign imm_i = instr[31:20];
  assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  // opcode and rs1/funct3 bits never feed an immediate
  assign unused_bits = ^{instr[19:12], instr[6:0]};

  always_comb begin
    if (is_branch) imm = {{(W-13){imm_b[12]}}, imm_b};
    else           imm = {{(W-12){imm_i[11]}}, imm_i};
  end

endmodule

// File: rtl/riscv_seq_ctrl.sv
// Multi-cycle control unit: fetches over a valid handshake, decodes addi/add/bne,
// drives the register-file/ALU controls and owns the PC.
//
// state  | meaning
// FETCH  | request instruction at pc, wait for imem_valid
// DECODE | register fields, immediate and instruction class
// EXEC   | control outputs active, pc updated at end of cycle
// ERROR  | illegal instruction or misaligned branch target; held until reset
module riscv_seq_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          Data_Width    = 32,
  parameter int          Address_Width = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  output logic                     imem_req,
  output logic [Data_Width-1:0]    imem_addr,
  input  logic [Data_Width-1:0]    imem_rdata,
  input  logic                     imem_valid,
  output logic [Address_Width-1:0] rs1,
  output logic [Address_Width-1:0] rs2,
  output logic [Address_Width-1:0] rd,
  output logic                     en,
  output logic                     ALUSrc,
  output logic [Data_Width-1:0]    ImmOp,
  output logic [2:0]               ALU_ctrl,
  input  logic                     eq,
  output logic [Data_Width-1:0]    pc,
  output logic                     halted,
  output logic                     retired
);

  import riscv_ctrl_pkg::*;

  state_t                state, state_nxt;
  instr_cls_t            cls, cls_dec;
  logic [Data_Width-1:0] instr;
  logic [Data_Width-1:0] imm_dec;
  logic [Data_Width-1:0] pc_seq, pc_tgt;
  logic                  is_branch;
  logic                  armed;
  logic                  req_hold;
  logic                  exec_fault;

  assign imem_addr = pc;
  assign is_branch = (instr[6:0] == OP_BRANCH);
  assign cls_dec   = classify(instr[31:0]);
  assign pc_seq    = pc + Data_Width'(4);
  assign pc_tgt    = pc + ImmOp;
  // only a taken branch can land off a word boundary
  assign exec_fault = (cls == CLS_BNE) && !eq && (pc_tgt[1:0] != 2'b00);

  riscv_seq_ctrl_imm_gen #(.W(Data_Width)) u_imm_gen (
    .instr     (instr[31:0]),
    .is_branch (is_branch),
    .imm       (imm_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  // armed keeps the request low in the cycle reset releases, so the
  // request never asserts combinationally from run while reset is active
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      FETCH: begin
        imem_req = armed && (req_hold || run);
        if (imem_req && imem_valid) state_nxt = DECODE;
      end
      DECODE:  state_nxt = (cls_dec == CLS_ILLEGAL) ? ERROR : EXEC;
      EXEC:    state_nxt = exec_fault ? ERROR : FETCH;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed    <= 1'b0;
      req_hold <= 1'b0;
      instr    <= '0;
      cls      <= CLS_ILLEGAL;
      pc       <= RESET_PC[Data_Width-1:0];
      rs1      <= '0;
      rs2      <= '0;
      rd       <= '0;
      en       <= 1'b0;
      ALUSrc   <= 1'b0;
      ImmOp    <= '0;
      ALU_ctrl <= ALU_ADD;
      halted   <= 1'b0;
      retired  <= 1'b0;
    end else begin
      armed    <= 1'b1;
      retired  <= 1'b0;
      // once issued, the request survives run dropping until it completes
      req_hold <= (state == FETCH) && imem_req && !imem_valid;
      case (state)
        FETCH: begin
          if (imem_req && imem_valid) instr <= imem_rdata;
        end
        DECODE: begin
          rs1      <= Address_Width'(instr[19:15]);
          rs2      <= Address_Width'(instr[24:20]);
          rd       <= Address_Width'(instr[11:7]);
          ImmOp    <= imm_dec;
          cls      <= cls_dec;
          ALUSrc   <= (cls_dec == CLS_ADDI);
          ALU_ctrl <= (cls_dec == CLS_BNE) ? ALU_SUB : ALU_ADD;
          en       <= ((cls_dec == CLS_ADDI) || (cls_dec == CLS_ADD)) && (instr[11:7] != 5'd0);
          if (cls_dec == CLS_ILLEGAL) halted <= 1'b1;
        end
        EXEC: begin
          en <= 1'b0;
          if (exec_fault) begin
            halted <= 1'b1;
          end else begin
            retired <= 1'b1;
            pc      <= ((cls == CLS_BNE) && !eq) ? pc_tgt : pc_seq;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_seq_ctrl.sv
// Self-checking bench for riscv_seq_ctrl: directed scenarios plus randomized
// addi/add/bne streams checked against an instruction-level pc/control model.
module tb_riscv_seq_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic [4:0]  rs1, rs2, rd;
  logic        en, ALUSrc;
  logic [31:0] ImmOp;
  logic [2:0]  ALU_ctrl;
  logic        eq = 1'b0;
  logic [31:0] pc;
  logic        halted, retired;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_pc;

  // observations captured by step_instr
  bit          o_timeout, o_moved;
  int          o_req_cycles;
  logic [31:0] o_addr, o_imm, o_pc, o_pc_rst;
  logic        o_req_dec, o_ret_dec, o_en, o_alusrc, o_ret_exec, o_halt_exec;
  logic        o_ret, o_halt, o_en_after, o_req_after, o_en_rst;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [2:0]  o_alu;

  always #5 clk = ~clk;

  riscv_seq_ctrl #(.RESET_PC(RST_PC), .Data_Width(32), .Address_Width(5)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .rs1(rs1), .rs2(rs2), .rd(rd), .en(en), .ALUSrc(ALUSrc), .ImmOp(ImmOp), .ALU_ctrl(ALU_ctrl),
    .eq(eq), .pc(pc), .halted(halted), .retired(retired)
  );

  function automatic logic [31:0] enc_i(input int off, input logic [4:0] s1, input logic [4:0] d);
    logic [11:0] m;
    m = off[11:0];
    return {m, s1, 3'b000, d, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
    return {7'b0000000, s2, s1, 3'b000, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_b(input int off, input logic [4:0] s1, input logic [4:0] s2);
    logic [12:0] b;
    b = off[12:0];
    return {b[12], b[10:5], s2, s1, 3'b001, b[4:1], b[11], 7'b1100011};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    imem_valid = 1'b0;
    eq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = RST_PC;
  endtask

  // One instruction: wait for request, answer after dly cycles, then observe
  // DECODE, EXEC and the cycle after EXEC. Caller is always at a negedge.
  task automatic step_instr(input logic [31:0] ins, input int dly, input logic eq_in,
                            input logic run_next, input bit abort);
    int n;
    o_timeout = 0; o_moved = 0; o_req_cycles = 0;
    imem_valid = 1'b0;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      o_timeout = 1;
      return;
    end
    o_addr = imem_addr;
    o_req_cycles = 1;
    for (int d = 0; d < dly; d++) begin
      @(negedge clk);
      if (imem_req) o_req_cycles++;
      if (imem_addr !== o_addr) o_moved = 1;
    end
    imem_valid = 1'b1;
    imem_rdata = ins;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    o_req_dec = imem_req;
    o_ret_dec = retired;
    eq = eq_in;
    @(negedge clk);
    o_rs1 = rs1; o_rs2 = rs2; o_rd = rd; o_en = en; o_alusrc = ALUSrc;
    o_imm = ImmOp; o_alu = ALU_ctrl; o_ret_exec = retired; o_halt_exec = halted;
    run = run_next;
    if (abort) begin
      #1 rst_n = 1'b0;
      #1 begin o_en_rst = en; o_pc_rst = pc; end
      #1 rst_n = 1'b1;
    end
    @(negedge clk);
    o_ret = retired; o_halt = halted; o_pc = pc; o_en_after = en; o_req_after = imem_req;
  endtask

  task automatic test_reset();
    run = 1'b1;
    rst_n = 1'b0;
    #3;
    tests++;
    if ({imem_req, rs1, rs2, rd, en, ALUSrc, ImmOp, ALU_ctrl, halted, retired} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got req=%b rs1=%0d rs2=%0d rd=%0d en=%b alusrc=%b imm=%h alu=%b halt=%b ret=%b, want all 0",
               imem_req, rs1, rs2, rd, en, ALUSrc, ImmOp, ALU_ctrl, halted, retired);
    end
    tests++;
    if (pc !== RST_PC) begin fails++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
    do_reset();
  endtask

  task automatic test_addi();
    step_instr(32'h00500513, 0, 1'b0, 1'b1, 0);
    tests++;
    if (o_timeout) begin fails++; $display("FAIL addi_req_timeout: no imem_req within 20 cycles"); return; end
    tests++;
    if (o_addr !== 32'h0) begin fails++; $display("FAIL addi_addr: got %h want 00000000", o_addr); end
    tests++;
    if ({o_rd, o_rs1, o_en, o_alusrc, o_imm, o_alu} !== {5'd10, 5'd0, 1'b1, 1'b1, 32'd5, 3'b000}) begin
      fails++;
      $display("FAIL addi_exec: got rd=%0d rs1=%0d en=%b alusrc=%b imm=%h alu=%b want rd=10 rs1=0 en=1 alusrc=1 imm=5 alu=000",
               o_rd, o_rs1, o_en, o_alusrc, o_imm, o_alu);
    end
    tests++;
    if ({o_req_dec, o_ret_exec, o_ret, o_en_after} !== 4'b0010) begin
      fails++;
      $display("FAIL addi_pulse: got req_dec=%b ret_exec=%b ret_after=%b en_after=%b want 0 0 1 0",
               o_req_dec, o_ret_exec, o_ret, o_en_after);
    end
    tests++;
    if (o_pc !== 32'h4) begin fails++; $display("FAIL addi_pc: got %h want 00000004", o_pc); end
    tests++;
    if (o_req_after !== 1'b1) begin fails++; $display("FAIL addi_back_to_back_req: got %b want 1", o_req_after); end
    exp_pc = 32'h4;
  endtask

  task automatic test_add();
    step_instr(32'h00B50633, 0, 1'b0, 1'b1, 0);
    tests++;
    if (o_timeout || o_addr !== 32'h4) begin fails++; $display("FAIL add_addr: got %h timeout=%0d want 00000004", o_addr, o_timeout); end
    tests++;
    if ({o_rs1, o_rs2, o_rd, o_alusrc, o_alu, o_en} !== {5'd10, 5'd11, 5'd12, 1'b0, 3'b000, 1'b1}) begin
      fails++;
      $display("FAIL add_exec: got rs1=%0d rs2=%0d rd=%0d alusrc=%b alu=%b en=%b want 10 11 12 0 000 1",
               o_rs1, o_rs2, o_rd, o_alusrc, o_alu, o_en);
    end
    tests++;
    if (o_ret_dec !== 1'b0) begin fails++; $display("FAIL retired_single_pulse: got %b want 0", o_ret_dec); end
    tests++;
    if (o_pc !== 32'h8) begin fails++; $display("FAIL add_pc: got %h want 00000008", o_pc); end
    exp_pc = 32'h8;
  endtask

  task automatic test_bne();
    step_instr(32'hFEB51EE3, 0, 1'b0, 1'b1, 0);
    tests++;
    if ({o_imm, o_alu, o_en, o_alusrc} !== {32'hFFFF_FFFC, 3'b001, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL bne_exec: got imm=%h alu=%b en=%b alusrc=%b want fffffffc 001 0 0", o_imm, o_alu, o_en, o_alusrc);
    end
    tests++;
    if (o_pc !== 32'h4) begin fails++; $display("FAIL bne_taken_pc: got %h want 00000004", o_pc); end
    step_instr(32'h00B50633, 0, 1'b0, 1'b1, 0);
    step_instr(32'hFEB51EE3, 0, 1'b1, 1'b1, 0);
    tests++;
    if (o_pc !== 32'hC || o_ret !== 1'b1) begin
      fails++;
      $display("FAIL bne_not_taken_pc: got pc=%h ret=%b want 0000000c 1", o_pc, o_ret);
    end
    exp_pc = 32'hC;
  endtask

  task automatic test_delay_and_run();
    bit req_seen;
    bit pc_moved;
    step_instr(32'h00100013, 3, 1'b0, 1'b0, 0);
    tests++;
    if (o_req_cycles != 4 || o_moved) begin
      fails++;
      $display("FAIL delayed_fetch: got req_cycles=%0d addr_moved=%0d want 4 0", o_req_cycles, o_moved);
    end
    tests++;
    if ({o_en, o_en_after} !== 2'b00 || o_pc !== exp_pc + 32'h4) begin
      fails++;
      $display("FAIL addi_x0: got en=%b en_after=%b pc=%h want 0 0 %h", o_en, o_en_after, o_pc, exp_pc + 32'h4);
    end
    exp_pc = exp_pc + 32'h4;
    // stray valid while idle must be ignored
    req_seen = o_req_after;
    pc_moved = 0;
    imem_valid = 1'b1;
    imem_rdata = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (imem_req) req_seen = 1;
      if (pc !== exp_pc) pc_moved = 1;
    end
    imem_valid = 1'b0;
    tests++;
    if (req_seen || pc_moved || halted !== 1'b0) begin
      fails++;
      $display("FAIL run_low_idle: got req_seen=%0d pc_moved=%0d halted=%b want 0 0 0", req_seen, pc_moved, halted);
    end
    run = 1'b1;
    step_instr(enc_r(5'd1, 5'd2, 5'd3), 1, 1'b0, 1'b1, 0);
    tests++;
    if (o_timeout || o_addr !== exp_pc || o_pc !== exp_pc + 32'h4) begin
      fails++;
      $display("FAIL resume_after_run: got addr=%h pc=%h timeout=%0d want %h %h", o_addr, o_pc, o_timeout, exp_pc, exp_pc + 32'h4);
    end
    exp_pc = exp_pc + 32'h4;
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      int          kind, off, dly;
      logic [4:0]  a, b, d;
      logic [31:0] ins, eimm, npc;
      logic        e;
      kind = $urandom_range(0, 2);
      a = 5'($urandom_range(0, 31));
      b = 5'($urandom_range(0, 31));
      d = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      dly = $urandom_range(0, 3);
      e = 1'($urandom_range(0, 1));
      off = 0;
      if (kind == 0) begin
        off = int'($urandom_range(0, 4095)) - 2048;
        ins = enc_i(off, a, d);
        npc = exp_pc + 32'h4;
      end else if (kind == 1) begin
        ins = enc_r(a, b, d);
        npc = exp_pc + 32'h4;
      end else begin
        off = (int'($urandom_range(0, 2047)) - 1024) * 4;
        ins = enc_b(off, a, b);
        npc = e ? exp_pc + 32'h4 : exp_pc + 32'(off);
      end
      eimm = 32'(off);
      step_instr(ins, dly, e, 1'b1, 0);
      tests++;
      if (o_timeout || o_addr !== exp_pc || o_req_cycles != dly + 1 || o_moved) begin
        fails++;
        $display("FAIL rand_fetch[%0d]: got addr=%h req_cycles=%0d moved=%0d timeout=%0d want %h %0d 0 0",
                 k, o_addr, o_req_cycles, o_moved, o_timeout, exp_pc, dly + 1);
      end
      tests++;
      if ({o_rs1, o_rs2, o_rd, o_en, o_alusrc, o_alu} !==
          {ins[19:15], ins[24:20], ins[11:7], (kind != 2) && (d != 5'd0), kind == 0, (kind == 2) ? 3'b001 : 3'b000}) begin
        fails++;
        $display("FAIL rand_ctrl[%0d]: ins=%h got rs1=%0d rs2=%0d rd=%0d en=%b alusrc=%b alu=%b", k, ins,
                 o_rs1, o_rs2, o_rd, o_en, o_alusrc, o_alu);
      end
      if (kind != 1) begin
        tests++;
        if (o_imm !== eimm) begin fails++; $display("FAIL rand_imm[%0d]: ins=%h got %h want %h", k, ins, o_imm, eimm); end
      end
      tests++;
      if (o_pc !== npc || o_ret !== 1'b1 || o_halt !== 1'b0) begin
        fails++;
        $display("FAIL rand_pc[%0d]: ins=%h eq=%b got pc=%h ret=%b halt=%b want %h 1 0", k, ins, e, o_pc, o_ret, o_halt, npc);
      end
      exp_pc = npc;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step_instr(enc_b(-4, 5'd1, 5'd2), 0, 1'b0, 1'b1, 0);
    tests++;
    if (o_pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_down: got %h want fffffffc", o_pc); end
    step_instr(enc_i(1, 5'd0, 5'd1), 0, 1'b0, 1'b1, 0);
    tests++;
    if (o_addr !== 32'hFFFF_FFFC || o_pc !== 32'h0) begin
      fails++;
      $display("FAIL wrap_up: got addr=%h pc=%h want fffffffc 00000000", o_addr, o_pc);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    step_instr(enc_b(6, 5'd3, 5'd4), 0, 1'b1, 1'b1, 0);
    tests++;
    if (o_pc !== 32'h4 || o_halt !== 1'b0 || o_ret !== 1'b1) begin
      fails++;
      $display("FAIL misaligned_not_taken: got pc=%h halt=%b ret=%b want 00000004 0 1", o_pc, o_halt, o_ret);
    end
    step_instr(enc_b(6, 5'd3, 5'd4), 0, 1'b0, 1'b1, 0);
    tests++;
    if (o_pc !== 32'h4 || o_halt !== 1'b1 || o_ret !== 1'b0 || o_req_after !== 1'b0) begin
      fails++;
      $display("FAIL misaligned_taken: got pc=%h halt=%b ret=%b req=%b want 00000004 1 0 0", o_pc, o_halt, o_ret, o_req_after);
    end
  endtask

  task automatic test_illegal();
    bit bad;
    do_reset();
    step_instr(32'h0000_0000, 0, 1'b0, 1'b1, 0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || pc !== RST_PC || halted !== 1'b1 || retired !== 1'b0 || en !== 1'b0) bad = 1;
    end
    tests++;
    if (o_halt_exec !== 1'b1 || bad) begin
      fails++;
      $display("FAIL illegal_zero: got halt=%b sticky_violation=%0d want 1 0", o_halt_exec, bad);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (halted !== 1'b0 || pc !== RST_PC) begin
      fails++;
      $display("FAIL illegal_reset_clear: got halted=%b pc=%h want 0 %h", halted, pc, RST_PC);
    end
    do_reset();
    step_instr(32'h40B50633, 0, 1'b0, 1'b1, 0);
    tests++;
    if (o_halt_exec !== 1'b1 || o_en !== 1'b0 || o_pc !== RST_PC || o_ret !== 1'b0) begin
      fails++;
      $display("FAIL illegal_funct7: got halt=%b en=%b pc=%h ret=%b want 1 0 %h 0", o_halt_exec, o_en, o_pc, o_ret, RST_PC);
    end
  endtask

  task automatic test_reset_in_exec();
    do_reset();
    step_instr(enc_i(8, 5'd0, 5'd5), 0, 1'b0, 1'b1, 0);
    step_instr(enc_r(5'd5, 5'd6, 5'd7), 0, 1'b0, 1'b1, 1);
    tests++;
    if (o_en !== 1'b1 || o_en_rst !== 1'b0 || o_pc_rst !== RST_PC) begin
      fails++;
      $display("FAIL reset_in_exec: got en_before=%b en_in_rst=%b pc_in_rst=%h want 1 0 %h", o_en, o_en_rst, o_pc_rst, RST_PC);
    end
    tests++;
    if (o_pc !== RST_PC || o_ret !== 1'b0 || o_en_after !== 1'b0) begin
      fails++;
      $display("FAIL reset_in_exec_after: got pc=%h ret=%b en=%b want %h 0 0", o_pc, o_ret, o_en_after, RST_PC);
    end
    step_instr(enc_i(1, 5'd0, 5'd1), 0, 1'b0, 1'b1, 0);
    tests++;
    if (o_timeout || o_addr !== RST_PC || o_pc !== RST_PC + 32'h4) begin
      fails++;
      $display("FAIL reset_in_exec_refetch: got addr=%h pc=%h timeout=%0d want %h %h", o_addr, o_pc, o_timeout, RST_PC, RST_PC + 32'h4);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_add();
    test_bne();
    test_delay_and_run();
    test_random();
    test_wrap();
    test_misaligned();
    test_illegal();
    test_reset_in_exec();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
